// File: rtl/bht_rmw_ctrl.sv
// Branch-history-table updater: queues resolved branches and applies saturating
// read-modify-write to a counter RAM. Define BHT_CLEAR_EN to add the table-clear sweep.
module bht_rmw_ctrl #(
   parameter int CTRWIDTH  = 2,
   parameter int LOGINDEX  = 8,
   parameter int LOGQ      = 2,
   parameter int INITVALUE = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                upd_valid_in,
   output logic                upd_ready_out,
   input  logic [LOGINDEX-1:0] upd_index_in,
   input  logic                upd_taken_in,
   output logic [LOGINDEX-1:0] ram_index_out,
   input  logic [CTRWIDTH-1:0] ram_data_in,
   output logic [CTRWIDTH-1:0] ram_data_out,
   output logic                ram_we_out,
   output logic                busy_out
`ifdef BHT_CLEAR_EN
   ,
   input  logic                clear_in
`endif
);

   localparam int QDEPTH = 1 << LOGQ;

`ifdef BHT_CLEAR_EN
   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_CLR} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;
`endif

   state_t               r_state, w_nxt;
   logic [LOGINDEX-1:0]  r_q_idx [QDEPTH];
   logic                 r_q_tkn [QDEPTH];
   logic [LOGQ-1:0]      r_wptr, r_rptr;
   logic [LOGQ:0]        r_cnt;
   logic [CTRWIDTH-1:0]  r_ctr;
   logic                 w_full, w_empty, w_push, w_pop, w_flush;
   logic [LOGINDEX-1:0]  w_head_idx;
   logic                 w_head_tkn;

   function automatic logic [CTRWIDTH-1:0] f_sat(input logic [CTRWIDTH-1:0] c, input logic t);
      if (t) return (&c) ? c : c + CTRWIDTH'(1);
      else   return (c == '0) ? c : c - CTRWIDTH'(1);
   endfunction

   assign w_full     = (r_cnt == (LOGQ+1)'(QDEPTH));
   assign w_empty    = (r_cnt == '0);
   assign w_push     = upd_valid_in && upd_ready_out;
   assign w_head_idx = r_q_idx[r_rptr];
   assign w_head_tkn = r_q_tkn[r_rptr];

`ifdef BHT_CLEAR_EN
   logic                r_clr_pend;
   logic [LOGINDEX-1:0] r_clr_idx;

   assign upd_ready_out = !w_full && !r_clr_pend && (r_state != S_CLR);
   assign busy_out      = !w_empty || (r_state != S_IDLE) || r_clr_pend;

   // A clear request arriving while the sweep runs is dropped, not re-queued.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_clr_pend <= 1'b0;
         r_clr_idx  <= '0;
      end else begin
         if (w_nxt == S_CLR && r_state != S_CLR) r_clr_pend <= 1'b0;
         else if (clear_in && r_state != S_CLR)  r_clr_pend <= 1'b1;
         r_clr_idx <= (r_state == S_CLR) ? r_clr_idx + LOGINDEX'(1) : '0;
      end
   end
`else
   assign upd_ready_out = !w_full;
   assign busy_out      = !w_empty || (r_state != S_IDLE);
`endif

   always_comb begin
      w_nxt         = r_state;
      w_pop         = 1'b0;
      w_flush       = 1'b0;
      ram_index_out = '0;
      ram_data_out  = '0;
      ram_we_out    = 1'b0;
      case (r_state)
         S_IDLE: begin
`ifdef BHT_CLEAR_EN
            if (r_clr_pend) begin
               w_nxt   = S_CLR;
               w_flush = 1'b1;
            end else
`endif
            if (!w_empty) w_nxt = S_RD;
         end
         S_RD: begin
            ram_index_out = w_head_idx;
            w_nxt         = S_WR;
         end
         S_WR: begin
            ram_index_out = w_head_idx;
            ram_we_out    = 1'b1;
            ram_data_out  = f_sat(r_ctr, w_head_tkn);
            w_pop         = 1'b1;
`ifdef BHT_CLEAR_EN
            if (r_clr_pend) begin
               w_nxt   = S_CLR;
               w_flush = 1'b1;
            end else
`endif
            // An entry pushed this cycle counts as "another entry" after the pop.
            w_nxt = (r_cnt > (LOGQ+1)'(1) || w_push) ? S_RD : S_IDLE;
         end
`ifdef BHT_CLEAR_EN
         S_CLR: begin
            ram_index_out = r_clr_idx;
            ram_data_out  = CTRWIDTH'(INITVALUE);
            ram_we_out    = 1'b1;
            if (&r_clr_idx) w_nxt = S_IDLE;
         end
`endif
         default: w_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_cnt   <= '0;
         r_ctr   <= '0;
      end else begin
         r_state <= w_nxt;
         if (r_state == S_RD) r_ctr <= ram_data_in;
         if (w_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
         end else begin
            if (w_push) r_wptr <= r_wptr + LOGQ'(1);
            if (w_pop)  r_rptr <= r_rptr + LOGQ'(1);
            r_cnt <= r_cnt + (LOGQ+1)'(w_push) - (LOGQ+1)'(w_pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_idx[r_wptr] <= upd_index_in;
         r_q_tkn[r_wptr] <= upd_taken_in;
      end
   end

endmodule
